// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the frame state encoding, parity-mode codes and frame-length helper.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Mode 2'b11 is treated the same as PARITY_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

  function automatic int frame_len(input int cpb, input int data_bits,
                                   input int stop_bits, input logic [1:0] mode);
    return cpb * (1 + data_bits + (parity_enabled(mode) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Payload handshake and serial-line bundle between the byte source and the UART TX.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_in;
  logic                 data_in_valid;
  logic [1:0]           parity_mode;
  logic                 send_break;
  logic                 uart_tx;
  logic                 data_in_ready;
  logic                 idle;

  modport master (
    output data_in, data_in_valid, parity_mode, send_break,
    input  uart_tx, data_in_ready, idle
  );

  modport slave (
    input  data_in, data_in_valid, parity_mode, send_break,
    output uart_tx, data_in_ready, idle
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLOCKS_PER_BIT-1 and flags the last cycle of a period.
// restart forces the count back to 0 so a new frame starts on an exact period.
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 18
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  output logic bit_end
);

  localparam int TW = clog2_min1(CLOCKS_PER_BIT);

  logic [TW-1:0] timer_q, timer_d;

  assign bit_end = (timer_q == TW'(CLOCKS_PER_BIT - 1));

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (restart || bit_end) timer_d = '0;
  end

  always_ff @(posedge clock) begin
    if (clear) timer_q <= '0;
    else       timer_q <= timer_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// Optional break generation is built when UART_TX_BREAK_EN is defined.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 18,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 2
) (
  input  logic             clock,
  input  logic             clear,
  uart_tx_frame_if.slave   bus
);

  localparam int IDX_W = clog2_min1((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 par_en_q, par_en_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 last_stop;
  logic                 ready;
  logic                 accept;
  logic                 restart;
  logic                 brk_restart;

`ifdef UART_TX_BREAK_EN
  logic brk_q, brk_d;
  logic brk_min_q, brk_min_d;
`else
  logic unused_send_break;
  assign unused_send_break = bus.send_break;
`endif

  assign last_stop = (state_q == ST_STOP) && (idx_q == IDX_W'(STOP_BITS - 1)) && bit_end;

  // A break request in IDLE masks ready so it always wins over a payload.
`ifdef UART_TX_BREAK_EN
  assign ready = ((state_q == ST_IDLE) && !bus.send_break) || (last_stop && !brk_q);
`else
  assign ready = (state_q == ST_IDLE) || last_stop;
`endif

  assign accept  = bus.data_in_valid && ready;
  assign restart = clear || accept || brk_restart;

  uart_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .clear  (clear),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    par_en_d    = par_en_q;
    idx_d       = idx_q;
    brk_restart = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d       = brk_q;
    brk_min_d   = brk_min_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (bus.send_break) begin
          state_d     = ST_BREAK;
          brk_d       = 1'b1;
          brk_min_d   = 1'b0;
          brk_restart = 1'b1;
        end
`endif
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          acc_d   = acc_q ^ shift_q[0];
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
`ifdef UART_TX_BREAK_EN
            brk_d   = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // Leaving mid-period restarts the timer so the stop bits are full length.
      ST_BREAK: begin
        if (bit_end) brk_min_d = 1'b1;
        if (!bus.send_break && (brk_min_q || bit_end)) begin
          state_d     = ST_STOP;
          idx_d       = '0;
          brk_restart = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Accept only happens in IDLE or the final stop cycle, so it overrides both.
    if (accept) begin
      state_d  = ST_START;
      shift_d  = bus.data_in;
      par_en_d = parity_enabled(bus.parity_mode);
      acc_d    = (bus.parity_mode == PARITY_ODD);
      idx_d    = '0;
    end
  end

  // Line value is computed from the next state so uart_tx is aligned with state_q.
  always_comb begin
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = acc_d;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      tx_q     <= 1'b1;
      acc_q    <= 1'b0;
      par_en_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      acc_q    <= acc_d;
      par_en_q <= par_en_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      brk_q     <= 1'b0;
      brk_min_q <= 1'b0;
    end else begin
      brk_q     <= brk_d;
      brk_min_q <= brk_min_d;
    end
  end
`endif

  assign bus.uart_tx       = tx_q;
  assign bus.data_in_ready = ready;
  assign bus.idle          = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: driver predicts frames, monitor decodes the line.
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 2;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          start;
    bit          rdy_last;
  } frame_t;

  logic clock = 1'b0;
  logic clear = 1'b1;

  always #5 clock = ~clock;

  uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_tx_frame #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS     (DB),
    .STOP_BITS     (SB)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  frame_t exp_q[$];
  int     checks     = 0;
  int     errors     = 0;
  int     cyc        = 0;
  int     busy_until = 0;
  int     last_acc   = 0;
  bit     mon_en     = 1'b0;
  bit     mon_abort  = 1'b0;
  frame_t mon_cur;
  int     mon_k      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference frame: list of line levels, one per bit period.
  function automatic frame_t model_frame(input logic [DB-1:0] d, input logic [1:0] m);
    frame_t f;
    int     n;
    f.bits = '0;
    n = 1;
    for (int i = 0; i < DB; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (m == 2'b01 || m == 2'b10) begin
      f.bits[n] = (^d) ^ (m == 2'b10);
      n++;
    end
    for (int i = 0; i < SB; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits    = n;
    f.start    = 0;
    f.rdy_last = 1'b1;
    return f;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [DB-1:0] d, input logic [1:0] m, input int gap);
    frame_t f;
    int     pred;
    int     waited;
    bit     got;
    logic   r;
    repeat (gap) step();
    if (cyc >= busy_until) begin
      chk("idle_before_frame", int'(bus.idle), 1);
      chk("ready_before_frame", int'(bus.data_in_ready), 1);
    end
    bus.data_in       = d;
    bus.parity_mode   = m;
    bus.data_in_valid = 1'b1;
`ifndef UART_TX_BREAK_EN
    bus.send_break    = 1'($urandom);
`endif
    pred   = (cyc + 1 > busy_until) ? cyc + 1 : busy_until;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clock);
      r = bus.data_in_ready;
      step();
      waited++;
      if (r === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      bus.data_in_valid = 1'b0;
      return;
    end
    chk("accept_cycle", cyc, pred);
    f          = model_frame(d, m);
    f.start    = cyc;
    exp_q.push_back(f);
    last_acc   = cyc;
    busy_until = cyc + f.nbits * CPB;
    // Scramble inputs right after accept; the frame must keep the latched values.
    bus.data_in_valid = 1'b0;
    bus.data_in       = DB'($urandom);
    bus.parity_mode   = 2'($urandom);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (mon_abort) begin
          mon_k     = 0;
          mon_abort = 1'b0;
        end else begin
          if (mon_k == 0 && bus.uart_tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("idle_line", int'(bus.uart_tx), 1);
            end else begin
              mon_cur = exp_q.pop_front();
              chk("start_cycle", cyc, mon_cur.start);
              mon_k = 1;
            end
          end else if (mon_k > 0) begin
            mon_k++;
          end
          if (mon_k > 0) begin
            chk("line_bit", int'(bus.uart_tx), int'(mon_cur.bits[(mon_k - 1) / CPB]));
            chk("ready_in_frame", int'(bus.data_in_ready),
                int'(mon_k == mon_cur.nbits * CPB && mon_cur.rdy_last));
            if (mon_k == mon_cur.nbits * CPB) mon_k = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.parity_mode   = 2'b00;
    bus.send_break    = 1'b0;
    clear             = 1'b1;
    step();
    step();
    chk("reset_tx", int'(bus.uart_tx), 1);
    chk("reset_idle", int'(bus.idle), 1);
    chk("reset_ready", int'(bus.data_in_ready), 1);
    clear      = 1'b0;
    busy_until = cyc;
    mon_en     = 1'b1;

    // 0xA5 with even, odd, none and the 2'b11 alias of none.
    send(8'hA5, 2'b01, 1);
    send(8'hA5, 2'b10, 3);
    send(8'hA5, 2'b00, 2);
    send(8'hA5, 2'b11, 4);

    // Back-to-back: second payload waits on the final stop cycle.
    send(8'h01, 2'b00, 2);
    send(8'h80, 2'b00, 0);
    send(8'h3C, 2'b01, 0);

    // Clear in cycle 15 of a frame.
    send(8'hC3, 2'b01, 2);
    while (cyc < last_acc + 14) step();
    clear     = 1'b1;
    mon_abort = 1'b1;
    step();
    chk("clear_tx", int'(bus.uart_tx), 1);
    chk("clear_idle", int'(bus.idle), 1);
    chk("clear_ready", int'(bus.data_in_ready), 1);
    clear      = 1'b0;
    busy_until = cyc;
    send(8'h5A, 2'b10, 0);

`ifdef UART_TX_BREAK_EN
    begin
      frame_t bf;
      int     e;
      while (cyc < busy_until) step();
      bus.send_break    = 1'b1;
      bus.data_in_valid = 1'b1;
      bus.data_in       = 8'h00;
      bus.parity_mode   = 2'b01;
      step();
      e                 = cyc;
      bus.send_break    = 1'b0;
      bus.data_in_valid = 1'b0;
      bf.bits           = '0;
      for (int i = 1; i <= SB; i++) bf.bits[i] = 1'b1;
      bf.nbits          = 1 + SB;
      bf.start          = e;
      bf.rdy_last       = 1'b0;
      exp_q.push_back(bf);
      busy_until        = e + bf.nbits * CPB;
      while (cyc < busy_until) step();
      chk("break_then_idle", int'(bus.idle), 1);
    end
`endif

    for (int n = 0; n < 30; n++) begin
      logic [DB-1:0] d;
      logic [1:0]    m;
      int            g;
      d = DB'($urandom);
      m = 2'($urandom);
      g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
      send(d, m, g);
    end

    while (cyc < busy_until + 3) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", mon_k, 0);
    chk("final_idle", int'(bus.idle), 1);
    chk("final_tx", int'(bus.uart_tx), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
